// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : if_stage                                                      |
// | Description : MIPS instruction-fetch stage: PC, ROM address/enable, IF/ID   |
// |               register, delay-slot branching, stall-pending branch, flush.  |
// |               Optional macro IF_ALIGN_CHECK_EN adds id_adel_o.              |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_target_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic [31:0] inst_rom_data_i,
    output logic [31:0] inst_rom_addr_o,
    output logic        inst_rom_ce_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        id_adel_o
`endif
);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pending;
    logic [31:0] r_pend_target;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        w_aligned;

`ifdef IF_ALIGN_CHECK_EN
    logic        r_id_adel;
    assign w_aligned = (r_pc[1:0] == 2'b00);
    assign id_adel_o = r_id_adel;
`else
    assign w_aligned = 1'b1;
`endif

    // Enable decoded from registered state only; no input reaches an output.
    assign inst_rom_addr_o = r_pc;
    assign inst_rom_ce_o   = (r_state == S_RUN) && w_aligned;
    assign id_pc_o         = r_id_pc;
    assign id_inst_o       = r_id_inst;
    assign id_valid_o      = r_id_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_VECTOR;
            r_pending     <= 1'b0;
            r_pend_target <= 32'h0000_0000;
            r_id_pc       <= 32'h0000_0000;
            r_id_inst     <= NOP_INST;
            r_id_valid    <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            r_id_adel     <= 1'b0;
`endif
        end else if (r_state == S_BOOT) begin
            // Branches are ignored here; only a flush may move the boot PC.
            r_state    <= S_RUN;
            r_pending  <= 1'b0;
            if (flush_i) begin
                r_pc <= flush_target_i;
            end
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            r_id_adel  <= 1'b0;
`endif
        end else if (flush_i) begin
            r_pc       <= flush_target_i;
            r_pending  <= 1'b0;
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            r_id_adel  <= 1'b0;
`endif
        end else if (stall_i) begin
            // Remember a branch resolved while stalled so it is not lost.
            if (branch_flag_i) begin
                r_pending     <= 1'b1;
                r_pend_target <= branch_target_i;
            end
        end else begin
            if (branch_flag_i) begin
                r_pc <= branch_target_i;
            end else if (r_pending) begin
                r_pc <= r_pend_target;
            end else begin
                r_pc <= r_pc + 32'd4;
            end
            r_pending  <= 1'b0;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
`ifdef IF_ALIGN_CHECK_EN
            r_id_inst  <= w_aligned ? inst_rom_data_i : NOP_INST;
            r_id_adel  <= !w_aligned;
`else
            r_id_inst  <= inst_rom_data_i;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_if_stage                                                   |
// | Description : Directed vector bench for if_stage with a combinational ROM.  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] rom_data;
    logic [31:0] rom_addr;
    logic        rom_ce;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign rom_data = rom(rom_addr);

    if_stage dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_i         (stall),
        .flush_i         (flush),
        .flush_target_i  (flush_target),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .inst_rom_data_i (rom_data),
        .inst_rom_addr_o (rom_addr),
        .inst_rom_ce_o   (rom_ce),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst),
        .id_valid_o      (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] ftgt;
        logic        br;
        logic [31:0] btgt;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_id_pc;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] ft,
                                input logic b, input logic [31:0] bt,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.flush = f; v.ftgt = ft; v.br = b; v.btgt = bt;
        v.exp_addr = ea; v.exp_valid = ev; v.exp_id_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] ea, input logic ece,
                             input logic ev, input logic [31:0] ep);
        chk({tag, " addr"}, rom_addr, ea);
        chk({tag, " ce"}, {31'd0, rom_ce}, {31'd0, ece});
        chk({tag, " valid"}, {31'd0, id_valid}, {31'd0, ev});
        chk({tag, " inst"}, id_inst, ev ? rom(ep) : NOP);
        if (ev) chk({tag, " id_pc"}, id_pc, ep);
    endtask

    task automatic drive(input logic s, input logic f, input logic [31:0] ft,
                         input logic b, input logic [31:0] bt);
        stall = s; flush = f; flush_target = ft; branch_flag = b; branch_target = bt;
    endtask

    initial begin
        // Sequential fetch from reset, branch, stall with pending branch, flush, wrap.
        vecs[0]  = mk(0,0,0,0,0,               32'h0000_0000, 0, 0);
        vecs[1]  = mk(0,0,0,0,0,               32'h0000_0004, 1, 32'h0000_0000);
        vecs[2]  = mk(0,0,0,0,0,               32'h0000_0008, 1, 32'h0000_0004);
        vecs[3]  = mk(0,0,0,0,0,               32'h0000_000C, 1, 32'h0000_0008);
        vecs[4]  = mk(0,0,0,0,0,               32'h0000_0010, 1, 32'h0000_000C);
        vecs[5]  = mk(0,0,0,1,32'h100,         32'h0000_0100, 1, 32'h0000_0010);
        vecs[6]  = mk(0,0,0,0,0,               32'h0000_0104, 1, 32'h0000_0100);
        vecs[7]  = mk(1,0,0,1,32'h200,         32'h0000_0104, 1, 32'h0000_0100);
        vecs[8]  = mk(1,0,0,0,0,               32'h0000_0104, 1, 32'h0000_0100);
        vecs[9]  = mk(1,0,0,0,0,               32'h0000_0104, 1, 32'h0000_0100);
        vecs[10] = mk(0,0,0,0,0,               32'h0000_0200, 1, 32'h0000_0104);
        vecs[11] = mk(0,0,0,0,0,               32'h0000_0204, 1, 32'h0000_0200);
        vecs[12] = mk(1,0,0,1,32'h300,         32'h0000_0204, 1, 32'h0000_0200);
        vecs[13] = mk(1,1,32'h180,1,32'h400,   32'h0000_0180, 0, 0);
        vecs[14] = mk(0,0,0,0,0,               32'h0000_0184, 1, 32'h0000_0180);
        vecs[15] = mk(0,1,32'hFFFF_FFF8,0,0,   32'hFFFF_FFF8, 0, 0);
        vecs[16] = mk(0,0,0,0,0,               32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
        vecs[17] = mk(0,0,0,0,0,               32'h0000_0000, 1, 32'hFFFF_FFFC);
        vecs[18] = mk(0,0,0,0,0,               32'h0000_0004, 1, 32'h0000_0000);
        vecs[19] = mk(1,0,0,1,32'h500,         32'h0000_0004, 1, 32'h0000_0000);
        vecs[20] = mk(1,0,0,1,32'h540,         32'h0000_0004, 1, 32'h0000_0000);
        vecs[21] = mk(0,0,0,1,32'h600,         32'h0000_0600, 1, 32'h0000_0004);
        vecs[22] = mk(0,0,0,0,0,               32'h0000_0604, 1, 32'h0000_0600);
        vecs[23] = mk(0,1,32'h38,0,0,          32'h0000_0038, 0, 0);
        vecs[24] = mk(0,0,0,0,0,               32'h0000_003C, 1, 32'h0000_0038);
        vecs[25] = mk(0,0,0,0,0,               32'h0000_0040, 1, 32'h0000_003C);
        vecs[26] = mk(1,0,0,0,0,               32'h0000_0040, 1, 32'h0000_003C);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #2;
        chk_state("reset", 32'h0, 1'b0, 1'b0, 32'h0);
        chk("reset id_pc", id_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk_state("boot", 32'h0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].ftgt, vecs[i].br, vecs[i].btgt);
            @(posedge clk); #1;
            chk_state($sformatf("vec%0d", i), vecs[i].exp_addr, 1'b1,
                      vecs[i].exp_valid, vecs[i].exp_id_pc);
        end

        // Asynchronous reset between edges while fetching at 0x40.
        drive(0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async rst", 32'h0, 1'b0, 1'b0, 32'h0);
        chk("async rst id_pc", id_pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk_state("reboot", 32'h0, 1'b0, 1'b0, 32'h0);
        // A branch during BOOT is ignored.
        drive(0, 0, 0, 1, 32'h700);
        @(posedge clk); #1;
        chk_state("boot branch", 32'h0, 1'b1, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_state("post boot", 32'h4, 1'b1, 1'b1, 32'h0);

        // A flush during BOOT relocates the PC and still enters RUN.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        drive(0, 1, 32'h80, 0, 0);
        @(posedge clk); #1;
        chk_state("boot flush", 32'h80, 1'b1, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_state("boot flush run", 32'h84, 1'b1, 1'b1, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction ROM.
- Holds the PC and drives the ROM address and chip-enable.
- Captures the ROM's combinational read data into the IF/ID pipeline register.
- Handles sequential fetch, branch redirect with MIPS delay slot, pipeline stall (branch held pending across stall), and exception flush.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first PC fetched after reset.
- NOP_INST, 32'h0000_0000, instruction word loaded into id_inst_o on flush/bubble.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- stall_i  input  1  hold PC and IF/ID register this cycle.
- flush_i  input  1  exception/eret redirect; highest priority.
- flush_target_i  input  32  PC loaded on flush.
- branch_flag_i  input  1  branch/jump taken, resolved in ID.
- branch_target_i  input  32  branch/jump destination.
- inst_rom_data_i  input  32  instruction word from ROM (combinational, same cycle as address).
- inst_rom_addr_o  output  32  fetch address (= PC).
- inst_rom_ce_o  output  1  ROM chip enable.
- id_pc_o  output  32  PC of the instruction held in IF/ID.
- id_inst_o  output  32  instruction held in IF/ID.
- id_valid_o  output  1  IF/ID holds a real instruction.

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is asynchronous, active-low.
- Reset (rst_n_i=0, async):
  - pc=RESET_VECTOR, ce=0, pending=0.
  - id_pc_o=0, id_inst_o=NOP_INST, id_valid_o=0.
  - inst_rom_addr_o=RESET_VECTOR, inst_rom_ce_o=0.
- FSM states:
  - BOOT: one cycle after reset release; ce=0, PC holds RESET_VECTOR; unconditionally -> RUN.
  - RUN: ce=1; normal fetch.
  - Reset mid-operation returns to BOOT immediately (async).
- inst_rom_ce_o=1 only in RUN. IF/ID captures only when ce=1; in BOOT it loads a bubble (NOP_INST, valid=0).
- Next-PC priority in RUN, evaluated each edge:
  1. flush_i: pc<=flush_target_i; IF/ID<=bubble; pending<=0. Overrides stall_i and branch.
  2. stall_i: pc, IF/ID and id outputs hold. If branch_flag_i=1 this cycle: pending<=1, pend_target<=branch_target_i. If pending already set, it is retained (a later branch_flag_i overwrites the target).
  3. branch_flag_i=1 or pending=1: pc<=branch_target_i (branch_flag_i wins over a pending target); pending<=0. IF/ID captures the current fetch normally; this is the delay slot and is not squashed.
  4. Otherwise: pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Normal IF/ID capture: id_pc_o<=pc, id_inst_o<=inst_rom_data_i, id_valid_o<=1.
- Latency: address presented in cycle N; instruction visible on id_inst_o from cycle N+1.
- Flush during BOOT: pc<=flush_target_i; state still advances to RUN.
- Branch in BOOT: ignored.
- No combinational path from stall/branch/flush inputs to any output; all outputs are registered or decoded from registered state.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output id_adel_o (1 bit), registered alongside IF/ID; reset 0.
  - Set when a captured PC has pc[1:0]!=0.
  - For such a fetch inst_rom_ce_o is forced 0, id_inst_o=NOP_INST, id_valid_o=1, so the exception can be taken in a later stage.
  - Bubble sets id_adel_o=0.
- Undefined: port absent; PC low bits ignored by the fetch logic; ROM sees the full address.

Test Plan:
- Reset then release, no stall -> cycle1 ce=0, addr=0; from cycle2 addr 0,4,8,...; id_pc_o lags addr by one cycle with id_valid_o=1 from cycle3.
- Branch at pc=0x10 (branch_flag_i=1, target=0x100) -> next addr 0x100; id_pc_o=0x10 captured (delay slot); then 0x104.
- stall_i=1 for 3 cycles with branch_flag_i=1 (target 0x200) in first stall cycle only -> addr/id outputs frozen; first cycle after stall addr=0x200.
- flush_i=1, flush_target_i=0x180, simultaneous stall_i=1 and branch_flag_i=1 -> next addr=0x180, id_valid_o=0, id_inst_o=NOP_INST, pending cleared.
- pc=0xFFFF_FFFC, no events -> next addr 0x0000_0000.
- rst_n_i low mid-run at pc=0x40 (asynchronous, between edges) -> outputs return to reset values immediately; one BOOT cycle after release, then fetch from RESET_VECTOR.
